// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider helper for the UART receiver
// and the future transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word stream: holding register contents with a valid/ready handshake.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output data_out, data_out_valid, parity_err, frame_err, overrun_err,
        input  data_out_ready
    );

    modport slave (
        input  data_out, data_out_valid, parity_err, frame_err, overrun_err,
        output data_out_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloaded with DIV-1, tick on terminal
// count. A synchronous clear restarts the phase so a tick follows DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic os_tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload on clear or terminal count, otherwise count down.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clr || cnt_q == '0) cnt_d = LOAD;
    end

    assign os_tick = (cnt_q == '0) && !clr;

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority vote, false-start
// rejection and a valid/ready holding register.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on the synchronised line
// ST_START  | confirming the start bit at mid-bit (vote 1 = glitch)
// ST_DATA   | collecting DATA_BITS payload bits, LSB first
// ST_PARITY | checking the parity bit against the payload
// ST_STOP   | sampling STOP_BITS stop bits; completes at last decision
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_rx,
    output logic             busy,
    uart_rx_param_if.master  out_if
);
    localparam int DIV = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [OSW-1:0] OS_S0   = OSW'(M - 1);
    localparam logic [OSW-1:0] OS_S1   = OSW'(M);
    localparam logic [OSW-1:0] OS_DEC  = OSW'(M + 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
    localparam logic           SC_LAST = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx_param: CLK_FREQ/(BAUDRATE*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 16 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even, 8..16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < 0 || PARITY > 2) begin : g_bad_fmt
        $error("uart_rx_param: unsupported frame format");
    end

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 samp0_q, samp0_d, samp1_q, samp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_int_q, par_int_d, fr_int_q, fr_int_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 overrun_q, overrun_d, busy_q, busy_d;
    logic                 os_tick, tick_clr, decide, vote, accept, complete;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (tick_clr),
        .os_tick (os_tick)
    );

    assign decide = os_tick && (os_cnt_q == OS_DEC);
    assign vote   = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);
    assign accept = valid_q && out_if.data_out_ready;

    // Next-state logic for synchroniser, bit timing, frame FSM and holding register.
    always_comb begin
        state_d    = state_q;
        sync1_d    = data_rx;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        samp0_d    = samp0_q;
        samp1_d    = samp1_q;
        shift_d    = shift_q;
        par_int_d  = par_int_q;
        fr_int_d   = fr_int_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        tick_clr   = 1'b0;
        complete   = 1'b0;

        if (accept) valid_d = 1'b0;

        if (os_tick) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
            if (os_cnt_q == OS_S0) samp0_d = sync2_q;
            if (os_cnt_q == OS_S1) samp1_d = sync2_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (hist_q && !sync2_q) begin
                    state_d    = ST_START;
                    tick_clr   = 1'b1;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_int_d  = 1'b0;
                    fr_int_d   = 1'b0;
                end
            end
            ST_START: begin
                if (decide) state_d = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BC_LAST) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    if (vote != ((^shift_q) ^ (PARITY == PARITY_ODD))) par_int_d = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (!vote) fr_int_d = 1'b1;
                    if (stop_cnt_q == SC_LAST) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word accepted this cycle frees the register for the new frame.
        if (complete) begin
            if (!valid_q || accept) begin
                data_out_d = shift_q;
                perr_d     = par_int_d;
                ferr_d     = fr_int_d;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // All receiver state; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            hist_q     <= 1'b1;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp0_q    <= 1'b1;
            samp1_q    <= 1'b1;
            shift_q    <= '0;
            par_int_q  <= 1'b0;
            fr_int_q   <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            samp0_q    <= samp0_d;
            samp1_q    <= samp1_d;
            shift_q    <= shift_d;
            par_int_q  <= par_int_d;
            fr_int_q   <= fr_int_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    assign out_if.data_out       = data_out_q;
    assign out_if.data_out_valid = valid_q;
    assign out_if.parity_err     = perr_q;
    assign out_if.frame_err      = ferr_q;
    assign out_if.overrun_err    = overrun_q;
    assign busy                  = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) at DIV = 2,
// 32 clk per bit. Expected words are queued at stimulus time and popped by
// per-instance monitors on every accepted word.
module tb_uart_rx_param;

    localparam int CF = 3_686_400;
    localparam int BR = 115_200;
    localparam int BIT = 32;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    logic rx_line [3];
    logic busy0, busy1, busy2;
    int   total = 0;
    int   bad = 0;
    int   ovr0 = 0, ovr1 = 0, ovr2 = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(7)) if2 ();

    uart_rx_param #(.CLK_FREQ(CF), .BAUDRATE(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst0), .data_rx(rx_line[0]), .busy(busy0), .out_if(if0));
    uart_rx_param #(.CLK_FREQ(CF), .BAUDRATE(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst1), .data_rx(rx_line[1]), .busy(busy1), .out_if(if1));
    uart_rx_param #(.CLK_FREQ(CF), .BAUDRATE(BR), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY(0), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst2), .data_rx(rx_line[2]), .busy(busy2), .out_if(if2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe};
        case (which)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One frame; stp[0] is the first stop bit. Line is left at end_lvl.
    task automatic send(input int which, input logic [8:0] d, input int nb,
                        input bit has_par, input logic pb,
                        input logic [1:0] stp, input int ns, input logic end_lvl);
        rx_line[which] = 1'b0;
        tick(BIT);
        for (int i = 0; i < nb; i++) begin
            rx_line[which] = d[i];
            tick(BIT);
        end
        if (has_par) begin
            rx_line[which] = pb;
            tick(BIT);
        end
        for (int i = 0; i < ns; i++) begin
            rx_line[which] = stp[i];
            tick(BIT);
        end
        rx_line[which] = end_lvl;
    endtask

    // Scoreboard monitors: every accepted word must match the queue head.
    always @(negedge clk) begin
        if (if0.overrun_err) ovr0++;
        if (if0.data_out_valid && if0.data_out_ready) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL u0_unexpected: got word 0x%0h, expected none", if0.data_out);
            end else begin
                e0 = q0.pop_front();
                chk("u0_data", 32'(if0.data_out), 32'(e0.d));
                chk("u0_perr", 32'(if0.parity_err), 32'(e0.pe));
                chk("u0_ferr", 32'(if0.frame_err), 32'(e0.fe));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.overrun_err) ovr1++;
        if (if1.data_out_valid && if1.data_out_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL u1_unexpected: got word 0x%0h, expected none", if1.data_out);
            end else begin
                e1 = q1.pop_front();
                chk("u1_data", 32'(if1.data_out), 32'(e1.d));
                chk("u1_perr", 32'(if1.parity_err), 32'(e1.pe));
                chk("u1_ferr", 32'(if1.frame_err), 32'(e1.fe));
            end
        end
    end

    always @(negedge clk) begin
        if (if2.overrun_err) ovr2++;
        if (if2.data_out_valid && if2.data_out_ready) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL u2_unexpected: got word 0x%0h, expected none", if2.data_out);
            end else begin
                e2 = q2.pop_front();
                chk("u2_data", 32'(if2.data_out), 32'(e2.d));
                chk("u2_perr", 32'(if2.parity_err), 32'(e2.pe));
                chk("u2_ferr", 32'(if2.frame_err), 32'(e2.fe));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;
        if0.data_out_ready = 1'b1;
        if1.data_out_ready = 1'b1;
        if2.data_out_ready = 1'b1;
        tick(5);
        chk("rst_data",    32'(if0.data_out), 32'h0);
        chk("rst_valid",   32'(if0.data_out_valid), 32'h0);
        chk("rst_perr",    32'(if0.parity_err), 32'h0);
        chk("rst_ferr",    32'(if0.frame_err), 32'h0);
        chk("rst_overrun", 32'(if0.overrun_err), 32'h0);
        chk("rst_busy",    32'(busy0), 32'h0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        tick(10);

        // 1: 8N1 0xA5
        push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b01, 1, 1'b1);
        tick(BIT);
        chk("t1_busy_idle", 32'(busy0), 32'h0);

        // 2: 6-clk glitch rejected, then 0x3C
        rx_line[0] = 1'b0;
        tick(4);
        chk("t2_busy_glitch", 32'(busy0), 32'h1);
        tick(2);
        rx_line[0] = 1'b1;
        tick(26);
        chk("t2_busy_reject", 32'(busy0), 32'h0);
        tick(BIT);
        push(0, 9'h03C, 1'b0, 1'b0);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 2'b01, 1, 1'b1);
        tick(2 * BIT);

        // 3: even parity, 0x3C has four ones -> parity bit should be 0
        push(1, 9'h03C, 1'b1, 1'b0);
        send(1, 9'h03C, 8, 1'b1, 1'b1, 2'b01, 1, 1'b1);
        tick(2 * BIT);
        push(1, 9'h03C, 1'b0, 1'b0);
        send(1, 9'h03C, 8, 1'b1, 1'b0, 2'b01, 1, 1'b1);
        tick(2 * BIT);

        // 4: framing error then break; no retrigger while low
        push(0, 9'h000, 1'b0, 1'b1);
        send(0, 9'h000, 8, 1'b0, 1'b0, 2'b00, 1, 1'b0);
        tick(3 * BIT);
        chk("t4_busy_break", 32'(busy0), 32'h0);
        rx_line[0] = 1'b1;
        tick(2 * BIT);
        push(0, 9'h081, 1'b0, 1'b0);
        send(0, 9'h081, 8, 1'b0, 1'b0, 2'b01, 1, 1'b1);
        tick(2 * BIT);

        // 5: overrun with consumer stalled
        if0.data_out_ready = 1'b0;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 1'b0, 1'b0, 2'b01, 1, 1'b1);
        tick(BIT);
        send(0, 9'h022, 8, 1'b0, 1'b0, 2'b01, 1, 1'b1);
        tick(BIT);
        chk("t5_overrun_cnt", 32'(ovr0), 32'd1);
        chk("t5_held_data",   32'(if0.data_out), 32'h11);
        chk("t5_held_valid",  32'(if0.data_out_valid), 32'h1);
        if0.data_out_ready = 1'b1;
        tick(4);
        chk("t5_valid_clear", 32'(if0.data_out_valid), 32'h0);

        // 6: 7N2, reset during data bit 4
        if2.data_out_ready = 1'b0;
        send(2, 9'h05A, 7, 1'b0, 1'b0, 2'b11, 2, 1'b1);
        tick(BIT);
        chk("t6_pre_data",  32'(if2.data_out), 32'h5A);
        chk("t6_pre_valid", 32'(if2.data_out_valid), 32'h1);
        rx_line[2] = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_line[2] = (i == 0 || i == 1) ? 1'b1 : 1'b0;
            tick(BIT);
        end
        rx_line[2] = 1'b1;
        tick(10);
        chk("t6_busy_mid", 32'(busy2), 32'h1);
        rst2 = 1'b1;
        #1;
        chk("t6_rst_data",  32'(if2.data_out), 32'h0);
        chk("t6_rst_valid", 32'(if2.data_out_valid), 32'h0);
        chk("t6_rst_ferr",  32'(if2.frame_err), 32'h0);
        chk("t6_rst_busy",  32'(busy2), 32'h0);
        if2.data_out_ready = 1'b1;
        tick(5);
        rst2 = 1'b0;
        tick(2 * BIT);
        push(2, 9'h05A, 1'b0, 1'b0);
        send(2, 9'h05A, 7, 1'b0, 1'b0, 2'b11, 2, 1'b1);
        tick(2 * BIT);
        push(2, 9'h02B, 1'b0, 1'b1);
        send(2, 9'h02B, 7, 1'b0, 1'b0, 2'b01, 2, 1'b1);
        tick(3 * BIT);

        chk("end_q0_left", 32'(q0.size()), 32'd0);
        chk("end_q1_left", 32'(q1.size()), 32'd0);
        chk("end_q2_left", 32'(q2.size()), 32'd0);
        chk("end_ovr0",    32'(ovr0), 32'd1);
        chk("end_ovr1",    32'(ovr1), 32'd0);
        chk("end_ovr2",    32'(ovr2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver; next generation of the team's fixed 8N1 receiver. It adds:
- configurable data bits, parity and stop bits;
- 2-FF input synchroniser and oversampled reception with 3-sample majority vote and false-start rejection;
- valid/ready output holding register with parity, framing and overrun reporting.

It sits between the FPGA RX pin and the byte-stream consumer feeding the AES command/data path.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz
- BAUDRATE, 115_200: line rate in baud
- OVERSAMPLE, 16: oversample ticks per bit; even, 8..16
- DATA_BITS, 8: payload bits per frame, 5..9
- PARITY, 0: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1: 1 or 2

Clocking is one clock. Reset is asynchronous and active-high.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data_rx  in  1  serial line, idle high, asynchronous to clk
- data_out  out  DATA_BITS  received payload, LSB = first bit on line
- data_out_valid  out  1  data_out and error flags are valid
- data_out_ready  in  1  consumer accepts word when valid && ready
- parity_err  out  1  parity mismatch for the word in data_out; 0 when PARITY = 0
- frame_err  out  1  a stop bit was sampled low for the word in data_out
- overrun_err  out  1  one-cycle pulse: completed frame dropped because the holding register was full
- busy  out  1  high from start-edge detection until return to IDLE

## Operation
- **Synchroniser.** data_rx passes through a 2-FF synchroniser (reset value 1), then a 1-FF history register for edge detection.
- **Tick generator.** DIV = CLK_FREQ / (BAUDRATE*OVERSAMPLE), integer truncation; must be ≥ 2 (elaboration error otherwise). os_tick pulses for one clk every DIV clocks.
- **Bit-phase counter.** os_cnt runs 0..OVERSAMPLE-1 per bit. It is cleared together with the divider on start-edge detection.
- **Sampling.** Samples are taken at os_cnt = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples and is decided on the M+1 tick.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge (previous 1, current 0).
  - START: at decision, vote 1 → IDLE (glitch, nothing reported); vote 0 → DATA.
  - DATA: one decision per bit, shifted in LSB-first. After DATA_BITS decisions → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: check the vote against XOR(payload) (even) or its inverse (odd); mismatch latches parity_err_int.
  - STOP: STOP_BITS decisions; any 0 latches frame_err_int. Completion occurs at the decision of the last stop bit, not at its end, to allow early resynchronisation. Then → IDLE.
- **Completion.**
  - If data_out_valid = 0: load data_out, parity_err, frame_err and set data_out_valid.
  - Otherwise: drop the frame, pulse overrun_err, and leave the held word and flags unchanged.
- **Handshake.** valid && ready clears data_out_valid next cycle. data_out and the flags keep their value until the next load.
- **Break condition.** A falling edge needs a prior 1, so a held-low line after a framing error cannot retrigger until it returns high.

## Timing
- **Reset values:** data_out = 0, data_out_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0. State = IDLE, counters = 0, synchroniser = 1.
- **Reset mid-frame:** the frame is abandoned immediately. The first full frame after rst deasserts is received correctly.
- **Input latency:** 2 clk synchroniser plus 1 clk edge detect.
- **Output latency:** data_out_valid rises 1 clk after the last stop-bit decision tick.
- **Simultaneous accept and completion:** ready accepted in the same cycle as a new completion → the new word is loaded, valid stays 1, and no overrun is reported.
- **Timing tolerance:** total error ≤ ±(M-1)/OVERSAMPLE of a bit across the frame.

## Structure
- **Package uart_pkg** holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the state encoding (localparam typedef);
  - a function computing DIV.
- **Sub-module uart_baud_tick:** divider with a synchronous clear input and an os_tick output, reusable by the planned uart_tx_param.
- The synchroniser, FSM and holding register are inline.

## Test plan
Bench settings: CLK_FREQ = 3_686_400, BAUDRATE = 115_200, OVERSAMPLE = 16, so DIV = 2 and 32 clk per bit.
1. 8N1, ready = 1, send 0xA5 → data_out = 0xA5, valid for 1 clk, all error flags 0, busy falls after the stop decision.
2. 8N1, 6-clk low glitch on an idle line → no valid, busy returns to 0 within 1 bit time, next frame 0x3C received correctly.
3. PARITY = 2, send 0x3C with parity bit 1 → data_out = 0x3C, parity_err = 1. Resend with parity bit 0 → parity_err = 0.
4. 8N1, send 0x00 with stop bit 0, then hold the line low for 3 bit times → frame_err = 1, data_out = 0x00. No second frame until the line goes high, then 0x81 is received correctly.
5. ready = 0, send 0x11 then 0x22 → data_out stays 0x11, overrun_err pulses once at the 0x22 completion. Raising ready consumes 0x11, and 0x22 never appears.
6. DATA_BITS = 7, STOP_BITS = 2: assert rst during data bit 4 → all outputs 0 immediately. After release, 0x5A is received with no errors. A second stop bit of 0 → frame_err = 1.
